// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter needs at least one bit even when a single step suffices.
  function automatic int cnt_width_f(input int width, input int digit);
    int steps;
    steps = width / digit;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder.
// SERIAL_ADDER_SUB_EN adds the input_sub request line.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             input_start;
  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic             input_C;
`ifdef SERIAL_ADDER_SUB_EN
  logic             input_sub;
`endif
  logic [WIDTH-1:0] output_S;
  logic             output_C;
  logic             output_busy;
  logic             output_done;

  modport master (
    output input_start, input_A, input_B, input_C,
`ifdef SERIAL_ADDER_SUB_EN
    output input_sub,
`endif
    input  output_S, output_C, output_busy, output_done
  );

  modport slave (
    input  input_start, input_A, input_B, input_C,
`ifdef SERIAL_ADDER_SUB_EN
    input  input_sub,
`endif
    output output_S, output_C, output_busy, output_done
  );
endinterface

// File: rtl/serial_adder_adder_digit.sv
// Combinational DIGIT-bit ripple of full-adder cells.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c_s;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c_s[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock, LSB first, registered carry.
// Define SERIAL_ADDER_SUB_EN to add the input_sub (A + ~B + C) mode.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder_if.slave bus
);

  localparam int             STEPS     = steps_f(WIDTH, DIGIT);
  localparam int             CW        = cnt_width_f(WIDTH, DIGIT);
  localparam logic [CW-1:0]  LAST_STEP = CW'(STEPS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, s_q, s_d;
  logic             carry_q, carry_d, c_q, c_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] b_in_s;
  logic [DIGIT-1:0] sum_digit_s;
  logic             cout_s;

  // Subtraction is folded into the latched B so the datapath only ever adds.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in_s = bus.input_sub ? ~bus.input_B : bus.input_B;
`else
  assign b_in_s = bus.input_B;
`endif

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (sum_digit_s),
    .cout (cout_s)
  );

  // Next-state and datapath: operands shift down, sum digits shift in at the top.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    c_d      = c_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.input_start) begin
          a_d     = bus.input_A;
          b_d     = b_in_s;
          carry_d = bus.input_C;
          step_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        carry_d  = cout_s;
        shadow_d = WIDTH'({sum_digit_s, shadow_q} >> DIGIT);
        if (step_q == LAST_STEP) begin
          s_d     = shadow_d;
          c_d     = cout_s;
          state_d = DONE;
        end else begin
          step_d  = step_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      s_q      <= '0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.output_S    = s_q;
  assign bus.output_C    = c_q;
  assign bus.output_busy = busy_q;
  assign bus.output_done = done_q;

endmodule
